// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wptr_full
//  Description : Write-side control of the asynchronous FIFO. Owns the
//                binary/Gray write pointer, brings the read Gray pointer into
//                the write domain through a 2-flop synchronizer, and derives
//                the memory write address, full, almost-full, fill level and
//                a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wptr_full #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   input  logic                  ovf_clr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  wfull,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  wovf
);

   // Pointers carry one extra wrap bit beyond the address width.
   localparam int                 c_PTR_W = ADDR_WIDTH + 1;
   localparam int                 c_MSB   = ADDR_WIDTH;
   localparam logic [c_PTR_W-1:0] c_AFULL = c_PTR_W'(AFULL_THRESH);

   logic [c_PTR_W-1:0] r_wbin;
   logic [c_PTR_W-1:0] r_wgray;
   logic [c_PTR_W-1:0] r_rq1;
   logic [c_PTR_W-1:0] r_rq2;
   logic               r_wfull;
   logic               r_walmost_full;
   logic [c_PTR_W-1:0] r_wlevel;
   logic               r_wovf;

   logic               w_push;
   logic [c_PTR_W-1:0] w_wbin_next;
   logic [c_PTR_W-1:0] w_wgray_next;
   logic [c_PTR_W-1:0] w_full_match;
   logic [c_PTR_W-1:0] w_rbin;
   logic [c_PTR_W-1:0] w_level_next;
   logic               w_full_next;
   logic               w_afull_next;

   // Next pointer, full compare and level, all against the synchronized
   // (and therefore possibly stale) read pointer, which only overstates fill.
   always_comb begin
      w_push       = winc & ~r_wfull;
      w_wbin_next  = r_wbin + {{ADDR_WIDTH{1'b0}}, w_push};
      w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
      // Full when the write pointer is one lap ahead: top two Gray bits
      // inverted, remaining bits equal.
      w_full_match = {~r_rq2[c_MSB:c_MSB-1], r_rq2[c_MSB-2:0]};
      w_full_next  = (w_wgray_next == w_full_match);
      w_rbin       = '0;
      for (int i = 0; i < c_PTR_W; i++) begin
         w_rbin[i] = ^(r_rq2 >> i);
      end
      w_level_next = w_wbin_next - w_rbin;
      w_afull_next = (w_level_next >= c_AFULL);
   end

   // Write pointer and occupancy flags.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_wbin         <= '0;
         r_wgray        <= '0;
         r_wfull        <= 1'b0;
         r_walmost_full <= 1'b0;
         r_wlevel       <= '0;
      end else begin
         r_wbin         <= w_wbin_next;
         r_wgray        <= w_wgray_next;
         r_wfull        <= w_full_next;
         r_walmost_full <= w_afull_next;
         r_wlevel       <= w_level_next;
      end
   end

   // Two-flop synchronizer for the read Gray pointer; only r_rq2 is consumed.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_rq1 <= '0;
         r_rq2 <= '0;
      end else begin
         r_rq1 <= rptr_gray;
         r_rq2 <= r_rq1;
      end
   end

   // Sticky overflow: a write attempt while full beats a same-cycle clear.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_wovf <= 1'b0;
      end else if (winc & r_wfull) begin
         r_wovf <= 1'b1;
      end else if (ovf_clr) begin
         r_wovf <= 1'b0;
      end
   end

   assign waddr        = r_wbin[ADDR_WIDTH-1:0];
   assign wptr_gray    = r_wgray;
   assign wfull        = r_wfull;
   assign walmost_full = r_walmost_full;
   assign wlevel       = r_wlevel;
   assign wovf         = r_wovf;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wptr_full
//  Description : Scoreboard bench for fifo_wptr_full. Stimulus pushes the
//                expected output values after each write-clock edge; a
//                monitor pops and compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wptr_full;

   localparam int c_AW = 4;

   localparam int c_SEL_ADDR  = 0;
   localparam int c_SEL_GRAY  = 1;
   localparam int c_SEL_LVL   = 2;
   localparam int c_SEL_FULL  = 3;
   localparam int c_SEL_AFULL = 4;
   localparam int c_SEL_OVF   = 5;

   typedef struct {
      string      name;
      int         sel;
      logic [4:0] exp;
   } exp_t;

   logic            wclk;
   logic            wrst;
   logic            winc;
   logic [c_AW:0]   rptr_gray;
   logic            ovf_clr;
   logic [c_AW-1:0] waddr;
   logic            wfull;
   logic [c_AW:0]   wptr_gray;
   logic            walmost_full;
   logic [c_AW:0]   wlevel;
   logic            wovf;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   fifo_wptr_full #(
      .ADDR_WIDTH   (4),
      .AFULL_THRESH (12)
   ) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .winc         (winc),
      .rptr_gray    (rptr_gray),
      .ovf_clr      (ovf_clr),
      .waddr        (waddr),
      .wfull        (wfull),
      .wptr_gray    (wptr_gray),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   // 10 ns write clock.
   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // Hard stop in case the stimulus never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   // Monitor: compare every queued expectation against the settled outputs.
   always @(negedge wclk) begin
      exp_t       e;
      logic [4:0] act;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sel)
            c_SEL_ADDR:  act = {1'b0, waddr};
            c_SEL_GRAY:  act = wptr_gray;
            c_SEL_LVL:   act = wlevel;
            c_SEL_FULL:  act = {4'b0, wfull};
            c_SEL_AFULL: act = {4'b0, walmost_full};
            default:     act = {4'b0, wovf};
         endcase
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
         end
      end
   end

   task automatic expect_one(input string name, input int sel, input logic [4:0] v);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = v;
      sb_q.push_back(e);
   endtask

   task automatic expect_all(input string tag, input logic [4:0] addr, input logic [4:0] gray,
                             input logic [4:0] lvl, input logic full, input logic af,
                             input logic ovf);
      expect_one({tag, ".waddr"},        c_SEL_ADDR,  addr);
      expect_one({tag, ".wptr_gray"},    c_SEL_GRAY,  gray);
      expect_one({tag, ".wlevel"},       c_SEL_LVL,   lvl);
      expect_one({tag, ".wfull"},        c_SEL_FULL,  {4'b0, full});
      expect_one({tag, ".walmost_full"}, c_SEL_AFULL, {4'b0, af});
      expect_one({tag, ".wovf"},         c_SEL_OVF,   {4'b0, ovf});
   endtask

   // Advance one edge; returns 1 ns later so outputs have updated.
   task automatic clk_step();
      @(posedge wclk);
      #1;
   endtask

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = 5'(b);
      return (v >> 1) ^ v;
   endfunction

   initial begin
      int p;
      int lvl;
      wrst      = 1'b1;
      winc      = 1'b1;
      rptr_gray = '0;
      ovf_clr   = 1'b0;

      // Reset held for two edges with a pending write.
      clk_step();
      clk_step();
      expect_all("reset", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      wrst = 1'b0;

      // Fill 16 entries with the read pointer parked at 0.
      for (int k = 1; k <= 16; k++) begin
         clk_step();
         expect_all($sformatf("fill%0d", k), 5'(k % 16), gray5(k), 5'(k),
                    (k == 16), (k >= 12), 1'b0);
      end
      expect_one("fill_gray16", c_SEL_GRAY, 5'b11000);

      // Writes while full set the sticky overflow without moving the pointer.
      clk_step();
      expect_all("ovf_set", 5'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1);
      ovf_clr = 1'b1;
      clk_step();
      expect_all("ovf_set_beats_clr", 5'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b1);
      winc = 1'b0;
      clk_step();
      expect_all("ovf_clear", 5'd0, 5'b11000, 5'd16, 1'b1, 1'b1, 1'b0);
      ovf_clr = 1'b0;

      // One read released: visible after the third edge, not before.
      rptr_gray = 5'b00001;
      clk_step();
      expect_one("rel_e1.wfull", c_SEL_FULL, 5'd1);
      expect_one("rel_e1.wlevel", c_SEL_LVL, 5'd16);
      clk_step();
      expect_one("rel_e2.wfull", c_SEL_FULL, 5'd1);
      expect_one("rel_e2.wlevel", c_SEL_LVL, 5'd16);
      clk_step();
      expect_all("rel_e3", 5'd0, 5'b11000, 5'd15, 1'b0, 1'b1, 1'b0);
      winc = 1'b1;
      clk_step();
      expect_all("refill", 5'd1, 5'b11001, 5'd16, 1'b1, 1'b1, 1'b0);
      winc = 1'b0;

      // Drain completely: read pointer catches up to binary 17.
      rptr_gray = gray5(17);
      clk_step();
      clk_step();
      clk_step();
      expect_all("drained", 5'd1, 5'b11001, 5'd0, 1'b0, 1'b0, 1'b0);

      // 40 writes with the read pointer trailing; pointer wraps 31 -> 0.
      winc = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         clk_step();
         p   = (17 + k) % 32;
         lvl = (k <= 5) ? k : 5;
         expect_all($sformatf("wrap%0d", k), 5'(p % 16), gray5(p), 5'(lvl),
                    1'b0, 1'b0, 1'b0);
         if (k == 14) expect_one("wrap_gray31", c_SEL_GRAY, 5'b10000);
         if (k == 15) expect_one("wrap_gray0", c_SEL_GRAY, 5'b00000);
         rptr_gray = gray5(17 + ((k > 2) ? (k - 2) : 0));
      end

      // Reset mid-fill with the read side reset alongside.
      wrst      = 1'b1;
      rptr_gray = '0;
      clk_step();
      expect_all("rst2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      wrst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         clk_step();
         expect_all($sformatf("mid%0d", k), 5'(k), gray5(k), 5'(k), 1'b0, 1'b0, 1'b0);
      end
      wrst = 1'b1;
      clk_step();
      expect_all("rst_mid", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      wrst = 1'b0;
      clk_step();
      expect_all("post_rst", 5'd1, 5'b00001, 5'd1, 1'b0, 1'b0, 1'b0);
      winc = 1'b0;

      // Let the monitor drain the scoreboard.
      @(negedge wclk);
      #1;
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side control stage of the asynchronous FIFO, placed directly upstream of the dual-port `fifo_mem` storage. It owns the binary/Gray write pointer and synchronizes the read-side Gray pointer into the write clock domain. From these it generates the `waddr` and `wfull` signals that drive `fifo_mem`, plus an almost-full flag, a fill level and a sticky overflow flag for the write-side client. Everything runs in the write clock domain. The only asynchronous input is the read pointer, which passes through a 2-flop synchronizer.

## Interface
- `ADDR_WIDTH`, 4: memory address width; depth = 2^ADDR_WIDTH (16).
- `AFULL_THRESH`, 12: fill level at or above which `walmost_full` asserts. Legal range 1..2^ADDR_WIDTH.

- `wclk`  in  1  write-domain clock; the only clock.
- `wrst`  in  1  reset, synchronous, active-high.
- `winc`  in  1  write request from the client. Ignored (except for overflow detection) while `wfull`=1.
- `rptr_gray`  in  ADDR_WIDTH+1  read-domain Gray pointer. Asynchronous to `wclk`; used only after synchronization.
- `ovf_clr`  in  1  clears `wovf`.
- `waddr`  out  ADDR_WIDTH  write address to `fifo_mem` (low bits of the binary pointer).
- `wfull`  out  1  FIFO full. Goes to `fifo_mem` and to the client.
- `wptr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read domain.
- `walmost_full`  out  1  registered flag, asserted when level >= `AFULL_THRESH`.
- `wlevel`  out  ADDR_WIDTH+1  registered fill level, 0..2^ADDR_WIDTH.
- `wovf`  out  1  sticky overflow: a write was attempted while full.

## Operation
- State registers, each ADDR_WIDTH+1 bits: `wbin`, `wgray`, `rq1`, `rq2`. Also `wfull`, `walmost_full`, `wlevel`, `wovf`.
- Reset (`wrst`=1 at a `wclk` edge): all registers go to 0. Outputs after reset: `waddr`=0, `wptr_gray`=0, `wfull`=0, `walmost_full`=0, `wlevel`=0, `wovf`=0.
- Push condition: `push = winc & ~wfull`.
- Next binary pointer: `wbin_next = wbin + push`, modulo 2^(ADDR_WIDTH+1). It wraps from all-ones to 0.
- Next Gray pointer: `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- Outputs from the pointer: `waddr = wbin[ADDR_WIDTH-1:0]`; `wptr_gray = wgray`.
- Synchronizer: each edge, `rq1 <= rptr_gray` and `rq2 <= rq1`. No other logic reads `rq1`.
- Full flag: `wfull <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]})`, where MSB = ADDR_WIDTH.
- Level: `rbin = gray2bin(rq2)`, where bit i is the XOR of `rq2` bits MSB..i. Then `wlevel <= (wbin_next - rbin)` modulo 2^(ADDR_WIDTH+1).
- Almost-full: `walmost_full <= (level_next >= AFULL_THRESH)`, using the same next-level value that is loaded into `wlevel`.
- Overflow flag update, in priority order:
  - if `winc & wfull`, then `wovf <= 1` (set wins over a simultaneous `ovf_clr`);
  - else if `ovf_clr`, then `wovf <= 0`.
- A rejected write changes neither `wbin` nor `wgray`.
- Pessimism is deliberate: `wfull` and `wlevel` use a delayed view of the read pointer, so they may overstate occupancy but never understate it.

## Timing
- Write acceptance: in a cycle with `winc`=1 and `wfull`=0, `fifo_mem` stores data at the current `waddr` on the edge. `waddr` and `wptr_gray` advance on that same edge.
- Full on the filling write: `wfull` is computed from `wgray_next`. It is therefore 1 in the cycle right after the write that fills the FIFO, so no accepted write is ever lost.
- Read release latency: a change on `rptr_gray` reaches `rq2` after 2 edges. It is reflected in `wfull`, `wlevel` and `walmost_full` after the 3rd edge.
- Simultaneous push and read release in the same cycle: the level reflects both the +1 and the new `rbin`.
- Reset has priority over `winc`, `ovf_clr` and synchronizer updates. Asserting reset mid-operation drops all pointers and flags to 0 on that edge. The read side must be reset in the same window.

## Test plan
- Reset: hold `wrst`=1 for 2 edges with `winc`=1 → all outputs are 0 and no pointer movement occurs.
- Fill: `rptr_gray`=0, 16 consecutive writes →
  - `waddr` steps 0..15, then returns to 0;
  - `walmost_full`=1 after the 12th write;
  - `wfull`=1 and `wlevel`=16 after the 16th write;
  - `wptr_gray`=5'b11000.
- Overflow: keep `winc`=1 for 2 more cycles while full →
  - `wovf`=1, with `waddr`/`wptr_gray` unchanged;
  - `ovf_clr` pulsed together with `winc` leaves `wovf`=1;
  - `ovf_clr` with `winc`=0 clears it.
- Release: from full, drive `rptr_gray`=5'b00001 → `wfull` falls and `wlevel`=15 exactly 3 edges later; the next write re-asserts `wfull`.
- Wrap: 40 writes while `rptr_gray` follows `wptr_gray` with a 2-cycle lag → no `wfull`, and the binary pointer wraps 31→0 (`wptr_gray` goes 5'b10000 → 5'b00000) with `wlevel` continuous.
- Reset mid-fill: assert `wrst` after 7 writes → all outputs are 0 on the next cycle, and the first write after release goes to `waddr`=0.
